// File: rtl/dmem_miss_engine.sv
// Cache miss engine for the Dmem block interface: it optionally writes back a dirty victim,
// then refills the missing block. A watchdog aborts a transfer that Dmem never answers.
module dmem_miss_engine #(
  parameter int ADDR_W     = 10,
  parameter int BLOCK_BITS = 128,
  parameter int TIMEOUT    = 1023
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  miss_valid,
  input  logic [ADDR_W-1:0]     miss_addr,
  input  logic                  miss_dirty,
  input  logic [ADDR_W-1:0]     victim_addr,
  input  logic [BLOCK_BITS-1:0] victim_data,
  output logic                  busy,
  output logic                  fill_valid,
  output logic [BLOCK_BITS-1:0] fill_data,
  output logic                  timeout_err,
  output logic                  mem_ren,
  output logic                  mem_wen,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [BLOCK_BITS-1:0] mem_din,
  input  logic                  mem_ready,
  input  logic                  mem_done,
  input  logic [BLOCK_BITS-1:0] mem_dout
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WB   = 2'd1,
    S_RD   = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_err;
  logic [ADDR_W-1:0]       r_miss_addr;
  logic [ADDR_W-1:0]       r_mem_addr;
  logic [BLOCK_BITS-1:0]   r_mem_din;
  logic [BLOCK_BITS-1:0]   r_fill_data;
  logic                    w_timeout;

  // The watchdog fires on the last permitted wait cycle, so a strobe is held exactly TIMEOUT cycles.
  assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (miss_valid) w_next = miss_dirty ? S_WB : S_RD;
      end
      S_WB: begin
        if (mem_done)       w_next = S_RD;
        else if (w_timeout) w_next = S_IDLE;
      end
      S_RD: begin
        if (mem_ready)      w_next = S_RESP;
        else if (w_timeout) w_next = S_IDLE;
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Address and write data only move on state changes, so they are stable for a whole strobe window.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_miss_addr <= '0;
      r_mem_addr  <= '0;
      r_mem_din   <= '0;
      r_fill_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (miss_valid) begin
            r_miss_addr <= miss_addr;
            r_mem_addr  <= miss_dirty ? victim_addr : miss_addr;
            if (miss_dirty) r_mem_din <= victim_data;
            r_cnt <= '0;
          end
        end
        S_WB: begin
          if (mem_done) begin
            r_mem_addr <= r_miss_addr;
            r_cnt      <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (w_timeout) r_err <= 1'b1;
          end
        end
        S_RD: begin
          if (mem_ready) begin
            r_fill_data <= mem_dout;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (w_timeout) r_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign mem_wen     = (r_state == S_WB);
  assign mem_ren     = (r_state == S_RD);
  assign fill_valid  = (r_state == S_RESP);
  assign fill_data   = r_fill_data;
  assign timeout_err = r_err;
  assign mem_addr    = r_mem_addr;
  assign mem_din     = r_mem_din;

endmodule

// File: tb/tb_dmem_miss_engine.sv
// Scoreboard bench for dmem_miss_engine: a Dmem stub with random latency answers the engine while
// a reference memory model predicts every writeback, refill address and fill block.
module tb_dmem_miss_engine;

  localparam int AW = 10;
  localparam int BB = 128;
  localparam int TO = 8;

  localparam int K_WR   = 0;
  localparam int K_RD   = 1;
  localparam int K_FILL = 2;

  typedef struct {
    int             kind;
    logic [AW-1:0]  addr;
    logic [BB-1:0]  data;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          miss_valid;
  logic [AW-1:0] miss_addr;
  logic          miss_dirty;
  logic [AW-1:0] victim_addr;
  logic [BB-1:0] victim_data;
  logic          busy;
  logic          fill_valid;
  logic [BB-1:0] fill_data;
  logic          timeout_err;
  logic          mem_ren;
  logic          mem_wen;
  logic [AW-1:0] mem_addr;
  logic [BB-1:0] mem_din;
  logic          mem_ready;
  logic          mem_done;
  logic [BB-1:0] mem_dout;

  dmem_miss_engine #(.ADDR_W(AW), .BLOCK_BITS(BB), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .miss_valid(miss_valid), .miss_addr(miss_addr), .miss_dirty(miss_dirty),
    .victim_addr(victim_addr), .victim_data(victim_data),
    .busy(busy), .fill_valid(fill_valid), .fill_data(fill_data), .timeout_err(timeout_err),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_ready(mem_ready), .mem_done(mem_done), .mem_dout(mem_dout)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;
  exp_t exp_q[$];

  logic [BB-1:0] stub_mem [1024];
  logic [BB-1:0] ref_mem  [1024];

  bit no_resp   = 1'b0;
  bit spur      = 1'b0;
  int fixed_lat = -1;

  int ren_len      = 0;
  int last_ren_len = 0;
  int wen_cycles   = 0;
  int n_fills      = 0;

  task automatic chk(input string nm, input logic [BB-1:0] act, input logic [BB-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [BB-1:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic pop_chk(input int kind, input string nm, input logic [AW-1:0] a,
                         input logic [BB-1:0] d, input bit use_data);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: unexpected event, got addr %h data %h, required none", nm, a, d);
    end else begin
      e = exp_q.pop_front();
      chk({nm, "_kind"}, BB'(kind), BB'(e.kind));
      chk({nm, "_addr"}, BB'(a), BB'(e.addr));
      if (use_data) chk({nm, "_data"}, d, e.data);
    end
  endtask

  // Dmem stub: answers each strobe window after a random or fixed latency, optionally with noise.
  initial begin
    int lat;
    bit act;
    mem_ready = 1'b0;
    mem_done  = 1'b0;
    mem_dout  = '0;
    act = 1'b0;
    lat = 0;
    forever begin
      @(posedge clock);
      #1;
      mem_ready = 1'b0;
      mem_done  = 1'b0;
      if (!(mem_ren || mem_wen)) begin
        act = 1'b0;
        if (spur && $urandom_range(0, 3) == 0) begin
          mem_ready = 1'b1;
          mem_done  = 1'b1;
          mem_dout  = rnd128();
        end
      end else begin
        if (!act) begin
          act = 1'b1;
          lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 4));
        end
        if (!no_resp && lat == 0) begin
          if (mem_wen) begin
            stub_mem[mem_addr] = mem_din;
            mem_done = 1'b1;
          end else begin
            mem_dout  = stub_mem[mem_addr];
            mem_ready = 1'b1;
          end
          act = 1'b0;
        end else begin
          if (lat > 0) lat--;
          if (spur && $urandom_range(0, 2) == 0) begin
            if (mem_ren) mem_done = 1'b1;
            else begin
              mem_ready = 1'b1;
              mem_dout  = rnd128();
            end
          end
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the engine completes a transfer or presents a fill.
  initial begin
    bit p_ren, p_wen, p_done_wb, p_fill;
    logic [AW-1:0] p_addr;
    logic [BB-1:0] p_din;
    p_ren = 0; p_wen = 0; p_done_wb = 0; p_fill = 0; p_addr = '0; p_din = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        p_ren = 0; p_wen = 0; p_done_wb = 0; p_fill = 0; ren_len = 0;
      end else begin
        n_chk++;
        a_excl: assert (!(mem_ren && mem_wen)) else begin
          n_fail++;
          $display("FAIL ren_wen_exclusive: got ren=1 wen=1, required at most one high");
        end
        if (p_fill)    chk("fill_one_cycle_after_ready", BB'(fill_valid), BB'(1));
        if (p_done_wb) chk("ren_cycle_after_done", BB'(mem_ren), BB'(1));
        if (p_ren && mem_ren) chk("ren_addr_stable", BB'(mem_addr), BB'(p_addr));
        if (p_wen && mem_wen) begin
          chk("wen_addr_stable", BB'(mem_addr), BB'(p_addr));
          chk("wen_din_stable", mem_din, p_din);
        end
        if (mem_ren) ren_len++;
        else if (p_ren) begin
          last_ren_len = ren_len;
          ren_len = 0;
        end
        if (mem_wen) wen_cycles++;
        p_fill = 0;
        p_done_wb = 0;
        if (mem_wen && mem_done) begin
          pop_chk(K_WR, "writeback", mem_addr, mem_din, 1'b1);
          p_done_wb = 1;
        end
        if (mem_ren && mem_ready) begin
          pop_chk(K_RD, "refill_read", mem_addr, '0, 1'b0);
          p_fill = 1;
        end
        if (fill_valid) begin
          n_fills++;
          pop_chk(K_FILL, "fill", r_dummy_addr(), fill_data, 1'b1);
        end
        p_ren = mem_ren; p_wen = mem_wen; p_addr = mem_addr; p_din = mem_din;
      end
    end
  end

  logic [AW-1:0] last_fill_addr = '0;
  function automatic logic [AW-1:0] r_dummy_addr();
    return last_fill_addr;
  endfunction

  // Issues one miss; on acceptance pushes the reference model's expected events.
  task automatic do_miss(input logic [AW-1:0] a, input logic d, input logic [AW-1:0] va,
                         input logic [BB-1:0] vd, input bit scram, input bit b2b, input bit exp_to);
    int guard;
    bit b0, from_resp, acc;
    int resp_cyc;
    exp_t e;
    guard = 0;
    while (busy && !(b2b && fill_valid) && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 200) begin
      chk("wait_idle_budget", BB'(busy), BB'(0));
      return;
    end
    from_resp = fill_valid;
    resp_cyc  = cyc;
    miss_valid = 1'b1; miss_addr = a; miss_dirty = d; victim_addr = va; victim_data = vd;
    acc = 1'b0;
    guard = 0;
    while (!acc && guard < 4) begin
      b0 = busy;
      @(posedge clock);
      #1;
      acc = !b0 && busy;
      guard++;
    end
    if (!acc) begin
      chk("miss_accept", BB'(busy), BB'(1));
      miss_valid = 1'b0;
      return;
    end
    if (from_resp) chk("b2b_accept_gap", BB'(cyc - resp_cyc), BB'(2));
    if (!exp_to) begin
      if (d) begin
        e.kind = K_WR; e.addr = va; e.data = vd; exp_q.push_back(e);
        ref_mem[va] = vd;
      end
      e.kind = K_RD;   e.addr = a; e.data = '0;         exp_q.push_back(e);
      e.kind = K_FILL; e.addr = a; e.data = ref_mem[a]; exp_q.push_back(e);
    end
    last_fill_addr = a;
    @(negedge clock);
    guard = 0;
    while (busy && !fill_valid && guard < 200) begin
      miss_valid = scram ? 1'($urandom()) : 1'b0;
      if (scram) begin
        miss_addr = AW'($urandom()); miss_dirty = 1'($urandom());
        victim_addr = AW'($urandom()); victim_data = rnd128();
      end
      @(negedge clock);
      guard++;
    end
    miss_valid = 1'b0;
    if (guard >= 200) chk("miss_complete_budget", BB'(busy), BB'(0));
  endtask

  initial begin
    int f0, w0;
    logic [AW-1:0] ra;
    reset = 1'b1; miss_valid = 1'b0; miss_addr = '0; miss_dirty = 1'b0;
    victim_addr = '0; victim_data = '0;
    for (int i = 0; i < 1024; i++) begin
      stub_mem[i] = {4{32'h5EED0000 ^ (i * 32'h9E37)}};
      ref_mem[i]  = stub_mem[i];
    end
    repeat (3) @(negedge clock);
    chk("reset_busy", BB'(busy), BB'(0));
    chk("reset_fill_valid", BB'(fill_valid), BB'(0));
    chk("reset_ren_wen", BB'({mem_ren, mem_wen}), BB'(0));
    chk("reset_timeout_err", BB'(timeout_err), BB'(0));
    chk("reset_mem_addr", BB'(mem_addr), BB'(0));
    chk("reset_mem_din", mem_din, '0);
    chk("reset_fill_data", fill_data, '0);
    reset = 1'b0;
    @(negedge clock);

    // Clean miss at 0x012 with a fixed 3-cycle Dmem latency.
    stub_mem[10'h012] = {16{8'hA5}};
    ref_mem[10'h012]  = {16{8'hA5}};
    fixed_lat = 3;
    w0 = wen_cycles; f0 = n_fills;
    do_miss(10'h012, 1'b0, 10'h3AB, rnd128(), 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    chk("t1_ren_window_len", BB'(last_ren_len), BB'(4));
    chk("t1_fill_data", fill_data, {16{8'hA5}});
    chk("t1_no_wen", BB'(wen_cycles - w0), BB'(0));
    chk("t1_one_fill", BB'(n_fills - f0), BB'(1));

    // Dirty miss: victim 0x3FF/0x1234, refill 0x001.
    do_miss(10'h001, 1'b1, 10'h3FF, BB'(128'h1234), 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    chk("t2_mem_din_held", mem_din, BB'(128'h1234));
    chk("t2_stub_written", stub_mem[10'h3FF], BB'(128'h1234));

    // Inputs scrambled while busy must not disturb the latched request.
    fixed_lat = -1;
    f0 = n_fills;
    do_miss(10'h0C3, 1'b1, 10'h0C3, rnd128(), 1'b1, 1'b0, 1'b0);
    @(negedge clock);
    chk("t3_one_fill", BB'(n_fills - f0), BB'(1));

    // Random traffic with back-to-back issue and spurious Dmem strobes.
    spur = 1'b1;
    for (int i = 0; i < 40; i++) begin
      ra = AW'($urandom());
      if ($urandom_range(0, 1) == 0) repeat ($urandom_range(0, 2)) @(negedge clock);
      do_miss(ra, 1'($urandom()), AW'($urandom()), rnd128(), 1'($urandom()),
              1'($urandom()), 1'b0);
    end
    spur = 1'b0;
    repeat (2) @(negedge clock);

    // Dmem never answers the refill: watchdog must abort after TIMEOUT cycles.
    no_resp = 1'b1;
    f0 = n_fills;
    do_miss(10'h2F0, 1'b0, 10'h000, rnd128(), 1'b0, 1'b0, 1'b1);
    @(negedge clock);
    chk("t4_ren_window_len", BB'(last_ren_len), BB'(TO));
    chk("t4_timeout_err", BB'(timeout_err), BB'(1));
    chk("t4_busy", BB'(busy), BB'(0));
    chk("t4_no_fill", BB'(n_fills - f0), BB'(0));

    // Reset in the middle of a writeback.
    miss_valid = 1'b1; miss_addr = 10'h155; miss_dirty = 1'b1;
    victim_addr = 10'h2AA; victim_data = rnd128();
    @(negedge clock);
    miss_valid = 1'b0;
    repeat (2) @(negedge clock);
    chk("t5_in_wb", BB'(mem_wen), BB'(1));
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    chk("t5_wen", BB'(mem_wen), BB'(0));
    chk("t5_busy", BB'(busy), BB'(0));
    chk("t5_outputs_zero", BB'({fill_valid, timeout_err, mem_ren, mem_addr}), BB'(0));
    chk("t5_mem_din_zero", mem_din, '0);
    chk("t5_fill_data_zero", fill_data, '0);
    no_resp = 1'b0;
    f0 = n_fills;
    do_miss(10'h155, 1'b0, 10'h000, rnd128(), 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    chk("t5_followup_fill", BB'(n_fills - f0), BB'(1));

    repeat (3) @(negedge clock);
    chk("scoreboard_drained", BB'(exp_q.size()), BB'(0));
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: simulation did not finish, required completion");
    $fatal(1, "time limit");
  end

endmodule
